// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl block.
// Optional prescaler is enabled with the COUNTER_CTRL_PRESCALE_EN macro.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_AUTO    = 1'b1;

    localparam logic [7:0] WRAP_MAX = 8'hFF;

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// Step-enable generator: one step pulse every PRESCALE cycles while not cleared.
// Only compiled when COUNTER_CTRL_PRESCALE_EN is defined.
`ifdef COUNTER_CTRL_PRESCALE_EN
module ctr_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic step_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign step_o = (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = step_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/counter_ctrl.sv
// Configurable terminal counter with one-shot / auto-reload modes.
// Define COUNTER_CTRL_PRESCALE_EN to count once every PRESCALE cycles instead of every cycle.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef COUNTER_CTRL_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wrap_cnt,
    output logic [1:0]       state_dbg
);

    // cfg handshake: a configuration transfers on a rising edge where cfg_valid
    // and cfg_ready are both high; cfg_ready is high only in IDLE, so a
    // requester must hold cfg_valid (and its data) until it sees cfg_ready.

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic [7:0]       wrap_q, wrap_d;
    logic             step;

`ifdef COUNTER_CTRL_PRESCALE_EN
    // Held clear outside RUN so every RUN entry starts a fresh prescale period.
    ctr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear_i ((state_q != ST_RUN) || stop),
        .step_o  (step)
    );
`else
    assign step = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        wrap_d    = wrap_q;
        cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    limit_d = cfg_limit;
                    mode_d  = cfg_mode;
                    wrap_d  = 8'd0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    q_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // stop has priority over a coincident terminal count.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (step) begin
                    if (q_q == limit_q) begin
                        done_d = 1'b1;
                        if (mode_q == MODE_AUTO) begin
                            q_d    = '0;
                            wrap_d = (wrap_q == WRAP_MAX) ? wrap_q : wrap_q + 8'd1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
            wrap_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q         = q_q;
    assign done      = done_q;
    assign wrap_cnt  = wrap_q;
    assign busy      = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign state_dbg = state_q;

endmodule
